// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the user-project SRAM arbiter.
// Holds the requester ID encoding, the SRAM command payload and the
// round-robin tie-break helper used by the top.
package sram_arb_pkg;

    localparam int unsigned SRAM_ADDR_W = 9;
    localparam int unsigned SRAM_DATA_W = 32;
    localparam int unsigned WMASK_W     = 4;
    localparam int unsigned WAIT_W      = 8;

    typedef enum logic [1:0] {
        PORT_WB   = 2'd0,
        PORT_IF   = 2'd1,
        PORT_DM   = 2'd2,
        PORT_NONE = 2'd3
    } port_e;

    typedef struct packed {
        logic                   we;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] wdata;
        logic [WMASK_W-1:0]     wmask;
    } sram_cmd_t;

    // Choose between the two core ports; on a tie the port not granted last wins.
    function automatic port_e rr_pick(input logic want_if, input logic want_dm,
                                      input port_e last);
        if (want_if && want_dm) begin
            return (last == PORT_IF) ? PORT_DM : PORT_IF;
        end else if (want_if) begin
            return PORT_IF;
        end else if (want_dm) begin
            return PORT_DM;
        end
        return PORT_NONE;
    endfunction

endpackage

// File: rtl/sram_arb_wait_ctr.sv
// Saturating starvation counter for one core port.
// Ports: clk/rst_n; req, gnt, boot_hold of the port; starve_c high once the
// port has been denied MAX_WAIT consecutive cycles.
module sram_arb_wait_ctr
    import sram_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic gnt,
    input  logic boot_hold,
    output logic starve_c
);

    localparam logic [WAIT_W-1:0] CNT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    // Count denied cycles; any grant, dropped request or loader mode restarts.
    always_comb begin
        cnt_d = cnt_q;
        if (boot_hold || !req || gnt) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starve_c = (cnt_q == CNT_MAX);

endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter for WB loader, Elpis IF and Elpis DM ports.
// Ports: clock/resetb; boot_hold; per-requester req/cmd in, gnt/rvalid/rdata
// out; sram_* command out and sram_dout read data in (one cycle latency).
// Grants are combinational in the request cycle; read data is routed back
// through a registered owner tag the following cycle.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = SRAM_ADDR_W,
    parameter int unsigned DATA_W   = SRAM_DATA_W,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic              boot_hold,
    input  logic              wb_req,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic [3:0]        wb_wmask,
    output logic              wb_gnt,
    output logic              wb_rvalid,
    output logic [DATA_W-1:0] wb_rdata,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [3:0]        dm_wmask,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              sram_csb,
    output logic              sram_web,
    output logic [3:0]        sram_wmask,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout
);

    port_e             gnt_id_c;
    port_e             rr_q, rr_d;
    logic              own_vld_q, own_vld_d;
    port_e             own_id_q, own_id_d;
    logic [DATA_W-1:0] wb_rdata_q, wb_rdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_starve_c, dm_starve_c;
    logic              wb_ok_c, if_ok_c, dm_ok_c;
    sram_cmd_t         wb_cmd_c, if_cmd_c, dm_cmd_c, cmd_c;

    sram_arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_if_wait (
        .clk       (clock),
        .rst_n     (resetb),
        .req       (if_req),
        .gnt       (if_gnt),
        .boot_hold (boot_hold),
        .starve_c  (if_starve_c)
    );

    sram_arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_dm_wait (
        .clk       (clock),
        .rst_n     (resetb),
        .req       (dm_req),
        .gnt       (dm_gnt),
        .boot_hold (boot_hold),
        .starve_c  (dm_starve_c)
    );

    // Nothing is granted while reset is held; loader mode locks out the cores.
    assign wb_ok_c = resetb && wb_req;
    assign if_ok_c = resetb && !boot_hold && if_req;
    assign dm_ok_c = resetb && !boot_hold && dm_req;

    // Priority: starving core port, then WB, then round-robin among cores.
    always_comb begin
        gnt_id_c = PORT_NONE;
        if ((if_ok_c && if_starve_c) || (dm_ok_c && dm_starve_c)) begin
            gnt_id_c = rr_pick(if_ok_c && if_starve_c, dm_ok_c && dm_starve_c, rr_q);
        end else if (wb_ok_c) begin
            gnt_id_c = PORT_WB;
        end else if (if_ok_c || dm_ok_c) begin
            gnt_id_c = rr_pick(if_ok_c, dm_ok_c, rr_q);
        end
    end

    // Granted port's command onto the SRAM pins; idle cycles drive zeros.
    always_comb begin
        wb_cmd_c = '{we: wb_we, addr: SRAM_ADDR_W'(wb_addr),
                     wdata: SRAM_DATA_W'(wb_wdata), wmask: wb_wmask};
        if_cmd_c = '{we: 1'b0, addr: SRAM_ADDR_W'(if_addr),
                     wdata: '0, wmask: '0};
        dm_cmd_c = '{we: dm_we, addr: SRAM_ADDR_W'(dm_addr),
                     wdata: SRAM_DATA_W'(dm_wdata), wmask: dm_wmask};
        cmd_c = '0;
        case (gnt_id_c)
            PORT_WB: cmd_c = wb_cmd_c;
            PORT_IF: cmd_c = if_cmd_c;
            PORT_DM: cmd_c = dm_cmd_c;
            default: cmd_c = '0;
        endcase
    end

    assign wb_gnt     = (gnt_id_c == PORT_WB);
    assign if_gnt     = (gnt_id_c == PORT_IF);
    assign dm_gnt     = (gnt_id_c == PORT_DM);
    assign sram_csb   = (gnt_id_c == PORT_NONE);
    assign sram_web   = !cmd_c.we;
    assign sram_wmask = cmd_c.wmask;
    assign sram_addr  = ADDR_W'(cmd_c.addr);
    assign sram_din   = DATA_W'(cmd_c.wdata);

    // Read return: owner tag selects who sees sram_dout; others hold.
    assign wb_rvalid = own_vld_q && (own_id_q == PORT_WB);
    assign if_rvalid = own_vld_q && (own_id_q == PORT_IF);
    assign dm_rvalid = own_vld_q && (own_id_q == PORT_DM);
    assign wb_rdata  = wb_rvalid ? sram_dout : wb_rdata_q;
    assign if_rdata  = if_rvalid ? sram_dout : if_rdata_q;
    assign dm_rdata  = dm_rvalid ? sram_dout : dm_rdata_q;

    always_comb begin
        rr_d       = rr_q;
        own_vld_d  = (gnt_id_c != PORT_NONE) && !cmd_c.we;
        own_id_d   = gnt_id_c;
        wb_rdata_d = wb_rdata;
        if_rdata_d = if_rdata;
        dm_rdata_d = dm_rdata;
        if ((gnt_id_c == PORT_IF) || (gnt_id_c == PORT_DM)) begin
            rr_d = gnt_id_c;
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            rr_q       <= PORT_DM;
            own_vld_q  <= 1'b0;
            own_id_q   <= PORT_NONE;
            wb_rdata_q <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            rr_q       <= rr_d;
            own_vld_q  <= own_vld_d;
            own_id_q   <= own_id_d;
            wb_rdata_q <= wb_rdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios followed by
// randomized requesters, all compared every cycle against a rule-level model.
module tb_sram_arbiter;

    localparam int unsigned AW   = 9;
    localparam int unsigned DW   = 32;
    localparam int unsigned MAXW = 8;

    logic          clock = 1'b0;
    logic          resetb;
    logic          boot_hold;
    logic [2:0]    req;
    logic [2:0]    we;
    logic [AW-1:0] addr  [3];
    logic [DW-1:0] wdata [3];
    logic [3:0]    wmask [3];

    logic          wb_gnt, wb_rvalid, if_gnt, if_rvalid, dm_gnt, dm_rvalid;
    logic [DW-1:0] wb_rdata, if_rdata, dm_rdata;
    logic          sram_csb, sram_web;
    logic [3:0]    sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout;

    always #5 clock = ~clock;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAXW)) dut (
        .clock(clock), .resetb(resetb), .boot_hold(boot_hold),
        .wb_req(req[0]), .wb_we(we[0]), .wb_addr(addr[0]), .wb_wdata(wdata[0]),
        .wb_wmask(wmask[0]), .wb_gnt(wb_gnt), .wb_rvalid(wb_rvalid), .wb_rdata(wb_rdata),
        .if_req(req[1]), .if_addr(addr[1]), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata),
        .dm_req(req[2]), .dm_we(we[2]), .dm_addr(addr[2]), .dm_wdata(wdata[2]),
        .dm_wmask(wmask[2]), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // SRAM array seen by the DUT, and the model's own copy of memory.
    logic [DW-1:0] mem     [512];
    logic [DW-1:0] ref_mem [512];

    // Reference model state.
    int            wcnt [3];
    int            last_core;
    bit            pend_v;
    int            pend_id;
    logic [DW-1:0] pend_data;
    logic [DW-1:0] rd_exp [3];
    int            g_exp;
    int            gh [$];

    logic          s_csb, s_web;
    logic [3:0]    s_mask;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_din;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [3:0] m);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic int pick(input bit a_if, input bit a_dm, input int last);
        if (a_if && a_dm) return (last == 1) ? 2 : 1;
        if (a_if) return 1;
        if (a_dm) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 3; p++) begin
            wcnt[p]   = 0;
            rd_exp[p] = '0;
        end
        last_core = 2;
        pend_v    = 1'b0;
        pend_id   = 3;
        pend_data = '0;
    endtask

    // Compare this cycle's DUT outputs with the model, then advance the model.
    task automatic model_cycle();
        int            g, obs;
        bit            ok_if, ok_dm, st_if, st_dm, eff_we;
        logic [46:0]   exp_s;
        logic [2:0]    exp_g, exp_v;
        logic [DW-1:0] exp_rd;
        logic [DW-1:0] got_rd [3];

        if (!resetb) model_reset();
        g = 3;
        if (resetb) begin
            ok_if = req[1] && !boot_hold;
            ok_dm = req[2] && !boot_hold;
            st_if = ok_if && (wcnt[1] >= int'(MAXW));
            st_dm = ok_dm && (wcnt[2] >= int'(MAXW));
            if (st_if || st_dm) g = pick(st_if, st_dm, last_core);
            else if (req[0]) g = 0;
            else g = pick(ok_if, ok_dm, last_core);
        end
        eff_we = (g == 0 || g == 2) ? we[g] : 1'b0;

        if (g == 3) exp_s = {1'b1, 1'b1, 4'h0, {AW{1'b0}}, {DW{1'b0}}};
        else if (g == 1) exp_s = {1'b0, 1'b1, 4'h0, addr[1], {DW{1'b0}}};
        else exp_s = {1'b0, !eff_we, wmask[g], addr[g], wdata[g]};
        exp_g = (g == 3) ? 3'b000 : 3'(1 << g);
        exp_v = pend_v ? 3'(1 << pend_id) : 3'b000;

        chk_eq("gnt", 64'({dm_gnt, if_gnt, wb_gnt}), 64'(exp_g));
        chk_eq("sram_cmd", 64'({sram_csb, sram_web, sram_wmask, sram_addr, sram_din}), 64'(exp_s));
        chk_eq("rvalid", 64'({dm_rvalid, if_rvalid, wb_rvalid}), 64'(exp_v));
        got_rd[0] = wb_rdata;
        got_rd[1] = if_rdata;
        got_rd[2] = dm_rdata;
        for (int p = 0; p < 3; p++) begin
            exp_rd = (pend_v && pend_id == p) ? pend_data : rd_exp[p];
            chk_eq((p == 0) ? "wb_rdata" : (p == 1) ? "if_rdata" : "dm_rdata",
                   64'(got_rd[p]), 64'(exp_rd));
        end

        obs = wb_gnt ? 0 : if_gnt ? 1 : dm_gnt ? 2 : 3;
        gh.push_back(obs);
        g_exp = g;

        if (resetb) begin
            if (pend_v) rd_exp[pend_id] = pend_data;
            pend_v = (g != 3) && !eff_we;
            if (pend_v) begin
                pend_id   = g;
                pend_data = ref_mem[addr[g]];
            end
            if (g != 3 && eff_we) ref_mem[addr[g]] = merge(ref_mem[addr[g]], wdata[g], wmask[g]);
            for (int p = 1; p < 3; p++) begin
                if (boot_hold || !req[p] || g == p) wcnt[p] = 0;
                else if (wcnt[p] < int'(MAXW)) wcnt[p] = wcnt[p] + 1;
            end
            if (g == 1 || g == 2) last_core = g;
        end
    endtask

    // One clock: check mid-cycle, latch the SRAM command, then play the SRAM.
    task automatic cycle();
        #4;
        model_cycle();
        s_csb  = sram_csb;
        s_web  = sram_web;
        s_mask = sram_wmask;
        s_addr = sram_addr;
        s_din  = sram_din;
        @(posedge clock);
        #1;
        if (!s_csb) begin
            if (!s_web) mem[s_addr] = merge(mem[s_addr], s_din, s_mask);
            else sram_dout = mem[s_addr];
        end
    endtask

    task automatic set_port(input int p, input bit r, input bit w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [3:0] m);
        req[p]   = r;
        we[p]    = (p == 1) ? 1'b0 : w;
        addr[p]  = a;
        wdata[p] = d;
        wmask[p] = m;
    endtask

    task automatic idle_all();
        for (int p = 0; p < 3; p++) set_port(p, 1'b0, 1'b0, '0, '0, 4'h0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, cnt, lat;
        bit found;

        for (int i = 0; i < 512; i++) begin
            mem[i]     = 32'(i) * 32'h9E37_79B1;
            ref_mem[i] = 32'(i) * 32'h9E37_79B1;
        end
        sram_dout = '0;
        resetb    = 1'b0;
        boot_hold = 1'b0;
        idle_all();
        model_reset();
        @(posedge clock);
        #1;

        // Reset then idle.
        repeat (3) cycle();
        resetb = 1'b1;
        repeat (10) cycle();

        // WB write then read back.
        set_port(0, 1'b1, 1'b1, 9'h1F0, 32'hDEAD_BEEF, 4'hF);
        cycle();
        set_port(0, 1'b1, 1'b0, 9'h1F0, '0, 4'h0);
        cycle();
        idle_all();
        #1;
        chk_eq("wb_readback", 64'({wb_rvalid, wb_rdata}), 64'({1'b1, 32'hDEAD_BEEF}));
        cycle();

        // IF and DM continuous: strict alternation starting with IF.
        base = gh.size();
        set_port(1, 1'b1, 1'b0, 9'h010, '0, 4'h0);
        set_port(2, 1'b1, 1'b0, 9'h1F0, '0, 4'h0);
        repeat (8) cycle();
        for (int i = 0; i < 8; i++) chk_eq("ifdm_alt", 64'(gh[base+i]), 64'((i % 2 == 0) ? 1 : 2));
        idle_all();
        cycle();

        // WB every cycle with IF continuous: one IF grant every MAXW+1 cycles.
        base = gh.size();
        set_port(0, 1'b1, 1'b0, 9'h003, '0, 4'h0);
        set_port(1, 1'b1, 1'b0, 9'h004, '0, 4'h0);
        repeat (3 * (MAXW + 1)) cycle();
        for (int i = 0; i < int'(3 * (MAXW + 1)); i++)
            chk_eq("wb_if_starve", 64'(gh[base+i]), 64'((i % int'(MAXW + 1) == int'(MAXW)) ? 1 : 0));
        idle_all();
        cycle();
        set_port(2, 1'b1, 1'b0, 9'h005, '0, 4'h0);
        cycle();
        idle_all();
        cycle();

        // Loader mode: only WB is served; cores wait from zero after release.
        boot_hold = 1'b1;
        set_port(0, 1'b1, 1'b0, 9'h006, '0, 4'h0);
        set_port(1, 1'b1, 1'b0, 9'h007, '0, 4'h0);
        set_port(2, 1'b1, 1'b0, 9'h008, '0, 4'h0);
        base = gh.size();
        repeat (20) cycle();
        cnt = 0;
        for (int i = 0; i < 20; i++) if (gh[base+i] == 0) cnt++;
        chk_eq("boot_wb_gnts", 64'(cnt), 64'(20));
        boot_hold = 1'b0;
        lat   = 0;
        found = 1'b0;
        for (int i = 0; i < int'(MAXW + 1) && !found; i++) begin
            cycle();
            lat++;
            if (gh[gh.size()-1] == 1) found = 1'b1;
        end
        chk_eq("boot_release_if", 64'(found), 64'(1));
        chk_eq("boot_release_lat", 64'(lat), 64'(MAXW + 1));
        idle_all();
        repeat (2) cycle();

        // Reset right after a DM read grant: the read is discarded.
        set_port(2, 1'b1, 1'b0, 9'h1F0, '0, 4'h0);
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            cycle();
            if (gh[gh.size()-1] == 2) found = 1'b1;
        end
        chk_eq("dm_read_gnt", 64'(found), 64'(1));
        resetb = 1'b0;
        set_port(0, 1'b1, 1'b0, 9'h001, '0, 4'h0);
        set_port(1, 1'b1, 1'b0, 9'h002, '0, 4'h0);
        repeat (3) cycle();
        resetb = 1'b1;
        idle_all();
        repeat (3) cycle();
        set_port(1, 1'b1, 1'b0, 9'h011, '0, 4'h0);
        set_port(2, 1'b1, 1'b0, 9'h012, '0, 4'h0);
        cycle();
        chk_eq("post_reset_tie", 64'(gh[gh.size()-1]), 64'(1));
        idle_all();
        repeat (2) cycle();

        // Randomized requesters obeying hold-until-grant.
        repeat (3000) begin
            for (int p = 0; p < 3; p++) begin
                if (req[p] && g_exp == p) req[p] = 1'b0;
                if (!req[p] && $urandom_range(0, 99) < 55) begin
                    set_port(p, 1'b1, 1'($urandom_range(0, 1)),
                             AW'($urandom_range(0, 15)) | (($urandom_range(0, 3) == 0) ? 9'h1F0 : 9'h000),
                             $urandom, 4'($urandom_range(0, 15)));
                end
            end
            if ($urandom_range(0, 149) == 0) boot_hold = !boot_hold;
            cycle();
        end
        boot_hold = 1'b0;
        idle_all();
        repeat (2) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single-port user-project SRAM (512 x 32) between three requesters: the Wishbone/management loader port (WB), the Elpis instruction-fetch port (IF) and the Elpis data-memory port (DM).
- Issues at most one SRAM access per cycle. Returns read data one cycle after the grant, routed to the requester that owned the access.
- Enforces boot-hold and starvation-free priority.
- Sits between core0 and custom_sram inside the user project wrapper.

Parameters:
- ADDR_W, 9, word-address width (512 words)
- DATA_W, 32, data width
- MAX_WAIT, 8, consecutive denied-request cycles after which a core port overrides WB priority (legal range 1..255)

Ports:
- clock  in  1  single clock
- resetb  in  1  asynchronous active-low reset
- boot_hold  in  1  when 1, IF/DM are never granted (loader mode)
- wb_req  in  1  WB access request
- wb_we  in  1  1 = write
- wb_addr  in  ADDR_W  word address
- wb_wdata  in  DATA_W  write data
- wb_wmask  in  4  byte enables
- wb_gnt  out  1  access accepted this cycle
- wb_rvalid  out  1  read data valid
- wb_rdata  out  DATA_W  read data
- if_req  in  1  fetch request (read only)
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  accepted
- if_rvalid  out  1  instruction valid
- if_rdata  out  DATA_W  instruction
- dm_req, dm_we, dm_addr, dm_wdata, dm_wmask, dm_gnt, dm_rvalid, dm_rdata  same as WB group
- sram_csb  out  1  active-low chip select
- sram_web  out  1  active-low write enable
- sram_wmask  out  4  byte mask
- sram_addr  out  ADDR_W  address
- sram_din  out  DATA_W  write data
- sram_dout  in  DATA_W  read data, valid one cycle after csb low

Behaviour:
- Arbitration is combinational within the request cycle. Exactly zero or one gnt is high per cycle.
- The granted port's command drives sram_* in the same cycle. The SRAM samples it at the next clock rising edge.
- Ungranted cycles: sram_csb=1, sram_web=1, sram_wmask=0, addr/din=0.
- Priority order:
  1. A starving core port (wait counter == MAX_WAIT).
  2. WB.
  3. IF/DM under round-robin.
- If both IF and DM are starving, round-robin decides between them.
- Round-robin pointer: a register holding the last-granted core port. It updates only on IF/DM grants; WB grants leave it unchanged. Reset value = DM, so IF wins the first IF/DM tie.
- Wait counters, one each for IF and DM (8-bit):
  - Increment on req && !gnt && !boot_hold, saturating at MAX_WAIT.
  - Clear on gnt, or when req drops.
  - Held at 0 while boot_hold=1.
- boot_hold=1: if_gnt=dm_gnt=0 unconditionally. WB is served every cycle it requests.
- Read return:
  - A registered owner tag {valid, id} is captured on any granted read.
  - Next cycle, the matching *_rvalid pulses for one cycle and *_rdata = sram_dout.
  - Non-owners' rdata hold their last value.
- Writes complete on gnt; they produce no rvalid.
- Back-to-back: a requester may hold req high across cycles. Each granted cycle is a separate access, giving throughput of 1 access/cycle.
- Requesters must hold req, addr, we, wdata and wmask stable until gnt.
- Reset (resetb low, asynchronous):
  - All gnt, rvalid and owner valid are 0. rdata registers are 0. Counters are 0. rr pointer = DM.
  - sram_csb=1, sram_web=1.
  - A read in flight at reset assertion is discarded: no rvalid after reset release.
- Simultaneous WB and core request at the same address: only the granted one executes. No merging.

Decomposition:
- Package sram_arb_pkg:
  - Port-ID enum: PORT_WB=2'd0, PORT_IF=2'd1, PORT_DM=2'd2, PORT_NONE=2'd3.
  - ADDR_W/DATA_W defaults.
  - Command struct {we, addr, wdata, wmask}.
- Sub-module sram_arb_wait_ctr: one saturating starvation counter with a starve flag output. Instantiated twice (IF, DM).

Test Plan:
- Reset then idle: sram_csb=1, all gnt/rvalid=0. Release resetb with no requests → outputs unchanged for 10 cycles.
- WB writes 0xDEADBEEF to addr 0x1F0, then reads it back → wb_gnt on each request cycle. wb_rvalid one cycle after the read grant, with wb_rdata=0xDEADBEEF. if/dm_rvalid stay 0.
- IF and DM request continuously, WB idle → grants alternate IF, DM, IF, DM starting with IF. Each port's rvalid follows its own grant by exactly 1 cycle.
- WB requests every cycle and IF requests continuously, MAX_WAIT=8 → IF is denied 8 cycles, granted on the 9th, then WB resumes. Pattern repeats: 1 IF grant per 9 cycles.
- boot_hold=1 with WB, IF and DM all requesting for 20 cycles → 20 WB grants, zero IF/DM grants, wait counters stay 0. Drop boot_hold → IF is granted within MAX_WAIT+1 cycles.
- Assert resetb low in the cycle after a DM read grant → no dm_rvalid after release. The first post-reset IF/DM tie goes to IF.
